wb_as_master: RTL and testbench

WB_AS_MASTER -- requirements
Module: wb_as_master

---
 rtl/wb_as_master_pkg.sv | 29 ++
 rtl/wb_as_master.sv | 157 +++++++++++++++
 tb/tb_wb_as_master.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_as_master_pkg.sv
// Shared AS command codes, FSM state encodings and debug view for the
// Wishbone-to-AS master and its companion as_wb_bridge.
package wb_as_master_pkg;

  localparam logic [7:0] AS_CMD_NOP   = 8'd0;
  localparam logic [7:0] AS_CMD_READ  = 8'd1;
  localparam logic [7:0] AS_CMD_WRITE = 8'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TX   = 2'd1;
  localparam logic [1:0] ST_RX   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Index of the final TX byte: reads stop after the address, writes add data.
  localparam logic [2:0] TX_LAST_RD = 3'd4;
  localparam logic [2:0] TX_LAST_WR = 3'd6;

  typedef struct packed {
    logic [1:0] state;
    logic [2:0] idx;
    logic       rx_idx;
    logic       err;
  } dbg_t;

  function automatic logic [7:0] as_cmd(input logic we);
    return we ? AS_CMD_WRITE : AS_CMD_READ;
  endfunction

endpackage

// File: rtl/wb_as_master.sv
// Wishbone slave that serialises each request into AS bytes (command, address,
// optional data), collects a 16-bit read response and terminates the WB cycle.
module wb_as_master
  import wb_as_master_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [7:0]  as_data_o,
  output logic        as_dstrb_o,
  input  logic        as_busy_i,
  input  logic [7:0]  as_data_i,
  input  logic        as_dstrb_i,
  output logic        as_busy_o,
  output dbg_t        dbg_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  // Handshakes: a WB request is taken in IDLE when cyc&stb are high and is
  // terminated by a single ack/err cycle in DONE, only while cyc&stb still
  // hold. On AS, a TX strobe fires only when as_busy_i is low and the
  // previous cycle carried no strobe; each RX strobe captured is answered by
  // a one-cycle as_busy_o pulse on the following cycle.

  logic [1:0]    r_state;
  logic          r_we;
  logic [31:0]   r_adr;
  logic [15:0]   r_dat;
  logic [2:0]    r_idx;
  logic          r_gap;
  logic          r_rx_idx;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [15:0]   r_rdata;
  logic [15:0]   r_dat_hold;
  logic          r_busy_o;

  logic          w_req;
  logic          w_tx_fire;
  logic          w_tx_last;
  logic [7:0]    w_tx_byte;
  logic          w_rx_cap;
  logic          w_timeout;
  logic          w_done_req;
  logic          w_ack;
  logic          w_err;

  assign w_req      = wb_cyc_i & wb_stb_i;
  assign w_tx_fire  = (r_state == ST_TX) & ~r_gap & ~as_busy_i & ~reset;
  assign w_tx_last  = r_we ? (r_idx == TX_LAST_WR) : (r_idx == TX_LAST_RD);
  assign w_rx_cap   = (r_state == ST_RX) & as_dstrb_i;
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_done_req = (r_state == ST_DONE) & w_req & ~reset;
  assign w_ack      = w_done_req & ~r_err;
  assign w_err      = w_done_req & r_err;

  always_comb begin
    w_tx_byte = AS_CMD_NOP;
    case (r_idx)
      3'd0:    w_tx_byte = as_cmd(r_we);
      3'd1:    w_tx_byte = r_adr[7:0];
      3'd2:    w_tx_byte = r_adr[15:8];
      3'd3:    w_tx_byte = r_adr[23:16];
      3'd4:    w_tx_byte = r_adr[31:24];
      3'd5:    w_tx_byte = r_dat[7:0];
      3'd6:    w_tx_byte = r_dat[15:8];
      default: w_tx_byte = AS_CMD_NOP;
    endcase
  end

  assign as_dstrb_o = w_tx_fire;
  assign as_data_o  = w_tx_fire ? w_tx_byte : 8'h00;
  assign as_busy_o  = r_busy_o;
  assign wb_ack_o   = w_ack;
  assign wb_err_o   = w_err;
  // Read data is only shown during a read ack; otherwise the last acked value.
  assign wb_dat_o   = (w_ack & ~r_we) ? r_rdata : r_dat_hold;
  assign dbg_o      = {r_state, r_idx, r_rx_idx, r_err};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_adr      <= 32'h0;
      r_dat      <= 16'h0;
      r_idx      <= 3'd0;
      r_gap      <= 1'b0;
      r_rx_idx   <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_rdata    <= 16'h0;
      r_dat_hold <= 16'h0;
      r_busy_o   <= 1'b0;
    end else begin
      r_busy_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_we    <= wb_we_i;
            r_adr   <= wb_adr_i;
            r_dat   <= wb_dat_i;
            r_idx   <= 3'd0;
            r_gap   <= 1'b0;
            r_err   <= 1'b0;
            r_state <= ST_TX;
          end
        end
        ST_TX: begin
          r_gap <= w_tx_fire;
          if (w_tx_fire) begin
            if (w_tx_last) begin
              r_idx    <= 3'd0;
              r_rx_idx <= 1'b0;
              r_cnt    <= '0;
              r_state  <= r_we ? ST_DONE : ST_RX;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ST_RX: begin
          r_cnt <= r_cnt + 1'b1;
          // A byte arriving on the timeout cycle still counts as a response.
          if (w_rx_cap) begin
            r_busy_o <= 1'b1;
            if (!r_rx_idx) begin
              r_rdata[7:0] <= as_data_i;
              r_rx_idx     <= 1'b1;
            end else begin
              r_rdata[15:8] <= as_data_i;
              r_state       <= ST_DONE;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_ack & ~r_we) r_dat_hold <= r_rdata;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_as_master.sv
// Directed bench for wb_as_master: drivers push expected AS bytes and WB
// responses into queues; a negedge monitor pops and compares them.
module tb_wb_as_master;
  import wb_as_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [7:0]  as_data_o;
  logic        as_dstrb_o;
  logic        as_busy_i;
  logic [7:0]  as_data_i;
  logic        as_dstrb_i;
  logic        as_busy_o;
  dbg_t        dbg;

  wb_as_master #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .as_data_o(as_data_o), .as_dstrb_o(as_dstrb_o), .as_busy_i(as_busy_i),
    .as_data_i(as_data_i), .as_dstrb_i(as_dstrb_i), .as_busy_o(as_busy_o),
    .dbg_o(dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int tx_cnt = 0;
  int exp_busy_left = 0;
  logic [15:0] last_rdata = 16'h0;
  logic [7:0]  exp_tx_q[$];
  logic [17:0] exp_rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event seen with no expectation queued", name);
  endtask

  always @(negedge clk) begin
    if (as_dstrb_o) begin
      chk("tx_busy_low", {31'd0, as_busy_i}, 32'd0);
      if (exp_tx_q.size() == 0) fail_now("tx_unexpected");
      else chk("tx_byte", {24'd0, as_data_o}, {24'd0, exp_tx_q.pop_front()});
      tx_cnt++;
    end
    if (as_busy_o) begin
      if (exp_busy_left == 0) fail_now("busy_unexpected");
      else exp_busy_left--;
    end
    if (wb_ack_o | wb_err_o) begin
      if (exp_rsp_q.size() == 0) fail_now("rsp_unexpected");
      else chk("wb_rsp", {14'd0, wb_err_o, wb_ack_o, wb_dat_o}, {14'd0, exp_rsp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_tx(input logic we, input logic [31:0] adr, input logic [15:0] dat);
    exp_tx_q.push_back(we ? 8'h02 : 8'h01);
    exp_tx_q.push_back(adr[7:0]);
    exp_tx_q.push_back(adr[15:8]);
    exp_tx_q.push_back(adr[23:16]);
    exp_tx_q.push_back(adr[31:24]);
    if (we) begin
      exp_tx_q.push_back(dat[7:0]);
      exp_tx_q.push_back(dat[15:8]);
    end
  endtask

  task automatic wait_tx(input int target, input string name);
    int n = 0;
    while (tx_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) chk(name, tx_cnt, target);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1 as_dstrb_i = 1'b1; as_data_i = b;
    @(posedge clk);
    #1 as_dstrb_i = 1'b0; as_data_i = 8'h00;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [15:0] dat,
                         input logic respond, input logic [7:0] lo, input logic [7:0] hi);
    int base;
    int n;
    bit done;
    push_tx(we, adr, dat);
    if (we) begin
      exp_rsp_q.push_back({2'b01, last_rdata});
    end else if (respond) begin
      exp_busy_left += 2;
      last_rdata = {hi, lo};
      exp_rsp_q.push_back({2'b01, last_rdata});
    end else begin
      exp_rsp_q.push_back({2'b10, last_rdata});
    end
    base = tx_cnt;
    @(posedge clk);
    #1 wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    if (!we && respond) begin
      wait_tx(base + 5, "rd_tx_wait");
      rx_byte(lo);
      rx_byte(hi);
    end
    n = 0;
    done = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (wb_ack_o | wb_err_o) done = 1;
    end
    if (!done) chk("rsp_wait", 32'd0, 32'd1);
    else if (we) chk("wr_latency_ge14", {31'd0, (n - 1) >= 14}, 32'd1);
    else if (respond) chk("rd_ack_latency", n, 32'd1);
    @(posedge clk);
    #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic busy_stall(input int target);
    wait_tx(target, "stall_wait");
    #1 as_busy_i = 1'b1;
    repeat (20) @(posedge clk);
    #1 as_busy_i = 1'b0;
  endtask

  task automatic idle_strobes(input logic [7:0] b);
    @(posedge clk);
    #1 as_dstrb_i = 1'b1; as_data_i = b;
    repeat (3) @(posedge clk);
    #1 as_dstrb_i = 1'b0; as_data_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_dat_hold", {16'd0, wb_dat_o}, {16'd0, last_rdata});
    chk("idle_busy_low", {31'd0, as_busy_o}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"},   {31'd0, wb_ack_o}, 32'd0);
    chk({tag, "_err"},   {31'd0, wb_err_o}, 32'd0);
    chk({tag, "_dat"},   {16'd0, wb_dat_o}, 32'd0);
    chk({tag, "_dstrb"}, {31'd0, as_dstrb_o}, 32'd0);
    chk({tag, "_data"},  {24'd0, as_data_o}, 32'd0);
    chk({tag, "_busy"},  {31'd0, as_busy_o}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    reset = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 32'h0; wb_dat_i = 16'h0;
    as_busy_i = 1'b0; as_data_i = 8'h00; as_dstrb_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 reset = 1'b0;

    idle_strobes(8'h77);

    wb_xfer(1'b1, 32'hdeadbeef, 16'hfeed, 1'b0, 8'h00, 8'h00);
    wb_xfer(1'b0, 32'hdeadbeef, 16'h0000, 1'b1, 8'hed, 8'hfe);

    idle_strobes(8'h99);

    base = tx_cnt;
    fork
      wb_xfer(1'b1, 32'h12345678, 16'ha5c3, 1'b0, 8'h00, 8'h00);
      busy_stall(base + 2);
    join

    wb_xfer(1'b0, 32'h00000010, 16'h0000, 1'b1, 8'h34, 8'h12);
    wb_xfer(1'b0, 32'h0badf00d, 16'h0000, 1'b0, 8'h00, 8'h00);

    // Master abandons a write after 3 bytes: the AS sequence must still finish.
    push_tx(1'b1, 32'h01020304, 16'h0506);
    base = tx_cnt;
    @(posedge clk);
    #1 wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h01020304; wb_dat_i = 16'h0506;
    wait_tx(base + 3, "drop_wait3");
    #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wait_tx(base + 7, "drop_wait7");
    repeat (5) @(posedge clk);
    chk("drop_tx_done", exp_tx_q.size(), 32'd0);

    // Reset three bytes into a write: remaining bytes and the ack are dropped.
    push_tx(1'b1, 32'h89abcdef, 16'h4321);
    base = tx_cnt;
    @(posedge clk);
    #1 wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h89abcdef; wb_dat_i = 16'h4321;
    wait_tx(base + 3, "rst_wait3");
    #1 reset = 1'b1;
    exp_tx_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    #1 reset = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    last_rdata = 16'h0;
    repeat (20) @(posedge clk);
    chk("midrst_no_tx", tx_cnt, base + 3);

    wb_xfer(1'b0, 32'hcafe0001, 16'h0000, 1'b1, 8'h5a, 8'h3c);

    repeat (5) @(posedge clk);
    chk("end_tx_q_empty", exp_tx_q.size(), 32'd0);
    chk("end_rsp_q_empty", exp_rsp_q.size(), 32'd0);
    chk("end_busy_all_seen", exp_busy_left, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
